load_store_unit: RTL and testbench

- Sits between the core's execute stage and the word-addressed data memory. The memory has a combinational read, a synchronous word-wide write and no byte enables.
- Performs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW through a request/response handshake, using a small FSM.
- Loads are byte/halfword-extracted and sign/zero-extended. Sub-word stores use a two-cycle read-modify-write.
- Misaligned, illegal-funct3 and out-of-range requests are rejected with an error code and cause no memory write.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings,
// FSM state encoding, response error codes and the request classifier.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK     = 2'b00,
        ERR_MISAL  = 2'b01,
        ERR_FUNCT3 = 2'b10,
        ERR_RANGE  = 2'b11
    } lsu_err_e;

    // Classify a request. Priority: illegal funct3, then misalignment,
    // then address range.
    function automatic lsu_err_e classify(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input logic [31:0] limit);
        logic legal;
        logic misal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;   // unsigned forms exist only for loads
            default:          legal = 1'b0;
        endcase
        case (funct3)
            F3_H, F3_HU: misal = addr[0];
            F3_W:        misal = |addr[1:0];
            default:     misal = 1'b0;
        endcase
        if (!legal)              return ERR_FUNCT3;
        else if (misal)          return ERR_MISAL;
        else if (addr >= limit)  return ERR_RANGE;
        else                     return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
//   word       : memory word (read data for loads, old word for stores)
//   addr_lo    : byte offset within the word
//   funct3     : RISC-V load/store funct3
//   wdata      : store data (low byte/half used for SB/SH)
//   load_data  : extracted and sign/zero-extended load result
//   store_word : word with the addressed byte/half replaced (little-endian)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default before the case statements so no
        // path leaves a value unassigned, which would otherwise infer a latch.
        byte_sel   = word[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = wdata;

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase

        case (funct3)
            F3_B: begin
                store_word = word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit between the execute stage and a word-addressed data
// memory (combinational read, synchronous word write, no byte enables).
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : request handshake (accepted when valid && ready)
//   resp_valid/rdata/err: one-cycle response pulse with load data / error code
//   mem_A/WD/WE/RD      : data memory interface
// Sub-word stores are a read (ACCESS) followed by a merged write (MERGE).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic [1:0]    resp_err,
    output logic [31:0]   mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD
);

    lsu_state_e    state_q, state_d;
    logic [31:0]   addr_q;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] merge_buf_q;
    logic [DW-1:0] resp_rdata_q;
    lsu_err_e      resp_err_q;

    logic          accept;
    lsu_err_e      req_err;
    logic          mem_we_raw;
    logic [DW-1:0] mem_wd_d;
    logic [DW-1:0] align_word;
    logic [DW-1:0] load_data;
    logic [DW-1:0] store_word;

    assign req_ready  = (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    assign req_err    = classify(req_we, req_funct3, req_addr, 32'(MEM_BYTES));
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_A      = {addr_q[31:2], 2'b00};
    assign mem_WD     = mem_wd_d;
    // Gate with rst directly so a reset landing mid-RMW never writes.
    assign mem_WE     = mem_we_raw & ~rst;

    // The aligner sees the live read word while loading and the buffered
    // old word while merging.
    assign align_word = (state_q == MERGE) ? merge_buf_q : mem_RD;

    lsu_align u_align (
        .word       (align_word),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            wdata_q      <= '0;
            merge_buf_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q       <= req_addr;
                we_q         <= req_we;
                funct3_q     <= req_funct3;
                wdata_q      <= req_wdata;
                resp_err_q   <= req_err;
                resp_rdata_q <= '0;   // stores and errors respond with zero
            end
            if (state_q == ACCESS && !we_q) resp_rdata_q <= load_data;
            if (state_q == ACCESS &&  we_q) merge_buf_q  <= mem_RD;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_we_raw = 1'b0;
        mem_wd_d   = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (req_err == ERR_OK) ? ACCESS : RESP;
            end
            ACCESS: begin
                if (we_q && funct3_q != F3_W) begin
                    state_d = MERGE;
                end else begin
                    state_d = RESP;
                    if (we_q) begin
                        mem_we_raw = 1'b1;
                        mem_wd_d   = wdata_q;
                    end
                end
            end
            MERGE: begin
                mem_we_raw = 1'b1;
                mem_wd_d   = store_word;
                state_d    = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized requests scored against a word-array reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(4096), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    // Data memory: combinational read, synchronous write.
    assign mem_RD = tb_mem[mem_A[11:2]];
    always @(posedge clk) begin
        if (pl_en)       tb_mem[pl_idx]      <= pl_val;
        else if (mem_WE) tb_mem[mem_A[11:2]] <= mem_WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 10'(idx);
        pl_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Reference: outcome of one request from the ISA rules, updating ref_mem.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [1:0] err, output logic [31:0] rdata,
                                  output int lat, output int nwe);
        int size, sh;
        bit legal;
        logic [31:0] word, v, mask;
        err = 2'b00; rdata = '0; lat = 1; nwe = 0;
        legal = we ? (f3 inside {F3_B, F3_H, F3_W})
                   : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        size = 1 << f3[1:0];
        if (!legal)                         err = 2'b10;
        else if ((addr % 32'(size)) != 0)   err = 2'b01;
        else if (addr >= 32'd4096)          err = 2'b11;
        if (err != 2'b00) return;
        word = ref_mem[addr[11:2]];
        sh   = 8 * int'(addr % 32'd4);
        if (!we) begin
            lat = 2;
            v = word >> sh;
            if (size == 1)      rdata = f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
            else if (size == 2) rdata = f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
            else                rdata = word;
        end else begin
            nwe  = 1;
            lat  = (size == 4) ? 2 : 3;
            mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << sh);
            ref_mem[addr[11:2]] = (word & ~mask) | ((wdata << sh) & mask);
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd, output logic [1:0] er);
        logic [1:0]  e_err;
        logic [31:0] e_rd;
        int e_lat, e_nwe;
        int nwe = 0;
        bit seen = 1'b0;
        model(we, f3, addr, wdata, e_err, e_rd, e_lat, e_nwe);
        rd = '0;
        er = '0;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_WE) nwe++;
            if (c == 1 && e_err == 2'b00) check({tag, "_memA"}, mem_A, addr & ~32'd3);
            if (resp_valid) begin
                seen = 1'b1;
                rd = resp_rdata;
                er = resp_err;
                check({tag, "_rdata"}, resp_rdata, e_rd);
                check({tag, "_err"}, 32'(resp_err), 32'(e_err));
                check({tag, "_latency"}, 32'(c), 32'(e_lat));
            end
        end
        check({tag, "_resp_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        if (mem_WE) nwe++;
        check({tag, "_pulse_len"}, 32'(resp_valid), 32'd0);
        check({tag, "_write_count"}, 32'(nwe), 32'(e_nwe));
        if (we && e_err == 2'b00)
            check({tag, "_mem_word"}, tb_mem[addr[11:2]], ref_mem[addr[11:2]]);
    endtask

    logic [31:0] rd, r1, r2;
    logic [1:0]  er;
    int          pulses, writes, accepts, resps;
    logic [2:0]  load_f3 [5];
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int          sel;

    initial begin
        load_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

        for (int i = 0; i < 32; i++) preload(i, $urandom);
        preload(2, 32'h1234_5678);
        preload(4, 32'h8000_FF80);

        // Reset state
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_A", mem_A, 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        check("rst_mem_WE", 32'(mem_WE), 32'd0);
        rst = 1'b0;

        // Directed loads
        do_req(1'b0, F3_B,  32'h09, '0, "lb_09", rd, er);  check("tp_lb_09", rd, 32'h0000_0056);
        do_req(1'b0, F3_H,  32'h0A, '0, "lh_0a", rd, er);  check("tp_lh_0a", rd, 32'h0000_1234);
        do_req(1'b0, F3_B,  32'h10, '0, "lb_10", rd, er);  check("tp_lb_10", rd, 32'hFFFF_FF80);
        do_req(1'b0, F3_BU, 32'h10, '0, "lbu_10", rd, er); check("tp_lbu_10", rd, 32'h0000_0080);
        do_req(1'b0, F3_H,  32'h12, '0, "lh_12", rd, er);  check("tp_lh_12", rd, 32'hFFFF_8000);
        do_req(1'b0, F3_W,  32'h10, '0, "lw_10", rd, er);  check("tp_lw_10", rd, 32'h8000_FF80);

        // Sub-word store via read-modify-write
        do_req(1'b1, F3_B, 32'h0B, 32'h0000_00AB, "sb_0b", rd, er);
        check("tp_sb_word", tb_mem[2], 32'hAB34_5678);

        // Error requests
        do_req(1'b0, F3_W,   32'h06,   '0, "err_misal", rd, er);  check("tp_err_misal", 32'(er), 32'd1);
        do_req(1'b0, 3'b011, 32'h08,   '0, "err_f3", rd, er);     check("tp_err_f3", 32'(er), 32'd2);
        do_req(1'b1, F3_W,   32'h1000, 32'h1, "err_range", rd, er); check("tp_err_range", 32'(er), 32'd3);

        // Reset during the MERGE cycle of an SH
        pulses = 0; writes = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h08; req_wdata = 32'h0000_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        if (resp_valid) pulses++;
        if (mem_WE) writes++;
        @(negedge clk);
        rst = 1'b1;
        #1 check("rmw_we_gated", 32'(mem_WE), 32'd0);
        if (resp_valid) pulses++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) check("rmw_ready_after_rst", 32'(req_ready), 32'd1);
            if (resp_valid) pulses++;
            if (mem_WE) writes++;
        end
        check("rmw_no_resp", 32'(pulses), 32'd0);
        check("rmw_no_write", 32'(writes), 32'd0);
        check("rmw_word_kept", tb_mem[2], 32'hAB34_5678);

        // Back-to-back SW then LW with req_valid held high throughout
        accepts = 0; resps = 0; writes = 0; r1 = '1; r2 = '0;
        ref_mem[8] = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (mem_WE) writes++;
            if (resp_valid) begin
                resps++;
                if (resps == 1) r1 = resp_rdata;
                else            r2 = resp_rdata;
            end
            if (req_valid && req_ready) accepts++;
            if (c == 1) begin req_we = 1'b0; req_wdata = '0; end
            if (resps >= 2) req_valid = 1'b0;
        end
        check("b2b_accepts", 32'(accepts), 32'd2);
        check("b2b_responses", 32'(resps), 32'd2);
        check("b2b_writes", 32'(writes), 32'd1);
        check("b2b_sw_rdata", r1, 32'd0);
        check("b2b_lw_rdata", r2, 32'hCAFE_F00D);
        check("b2b_mem_word", tb_mem[8], ref_mem[8]);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rf3 = 3'($urandom_range(0, 7));
            else if (rw)                   rf3 = 3'($urandom_range(0, 2));
            else                           rf3 = load_f3[$urandom_range(0, 4)];
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      raddr = 32'd4096 + 32'($urandom_range(0, 255));
            else if (sel == 1) raddr = $urandom;
            else               raddr = 32'($urandom_range(0, 127));
            do_req(rw, rf3, raddr, $urandom, "rnd", rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
